branch_stats_unit: RTL

Parametrised branch-prediction statistics collector attached to the EX stage, next to the branch resolution logic. For every non-bubble instruction it counts branches and mispredictions, broken down per branch type. It also tracks predicted-taken branches and the longest run of consecutive mispredictions. Counters saturate, can be frozen or cleared synchronously, and are read through a registered address/data port so a debug/MMIO shim can sample them.

---
 rtl/branch_stats_unit_if.sv | 23 ++
 rtl/branch_stats_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_stats_unit_if.sv
// Read port of branch_stats_unit, grouped so a debug/MMIO shim can bind to it.
//
// Handshake: the master raises rd_en with rd_addr for one cycle. Exactly one
// cycle later the slave presents rd_valid = 1 with rd_data. There is no
// backpressure. rd_data holds its last value while rd_valid = 0.
//
// Signals:
//   rd_en    master -> slave  read request
//   rd_addr  master -> slave  counter select
//   rd_data  slave -> master  registered read data
//   rd_valid slave -> master  rd_data valid, one cycle after rd_en
interface branch_stats_unit_if #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;

  modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
  modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/branch_stats_unit.sv
// Branch-prediction statistics collector for the EX stage.
// Counts branches, mispredictions (total and per branch type), predicted-taken
// branches, retired non-bubble instructions and the current/longest run of
// consecutive mispredictions. Counters saturate at all-ones; a saturated
// increment sets the sticky overflow flag.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active-low
//   bubbleE  EX holds a bubble (no event)
//   br_type  branch type, 0 = NOBRANCH
//   predict  front-end predicted taken
//   brFlush  misprediction flush for this instruction
//   freeze   hold all counters
//   clear    synchronous clear of all counters and overflow
//   rd       read port (branch_stats_unit_if.slave)
//   overflow sticky saturation flag
//
// Address map: 0 TOT_BR, 1 TOT_MISS, 2 PRED_T, 3 MAX_STREAK, 4 INSTR,
// 5 CUR_STREAK, 8+t BR[t] (t>=1), 16+t MISS[t]; everything else reads 0.
module branch_stats_unit #(
  parameter int CNT_W     = 32,
  parameter int NUM_TYPES = 7,
  parameter int TYPE_W    = 3,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubbleE,
  input  logic [TYPE_W-1:0] br_type,
  input  logic              predict,
  input  logic              brFlush,
  input  logic              freeze,
  input  logic              clear,
  branch_stats_unit_if.slave rd,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] tot_br, tot_miss, pred_t, max_streak, instr, cur_streak;
  logic [CNT_W-1:0] br_cnt   [NUM_TYPES];
  logic [CNT_W-1:0] miss_cnt [NUM_TYPES];

  logic [CNT_W-1:0] tot_br_nxt, tot_miss_nxt, pred_t_nxt, max_streak_nxt;
  logic [CNT_W-1:0] instr_nxt, cur_streak_nxt;
  logic [CNT_W-1:0] br_cnt_nxt   [NUM_TYPES];
  logic [CNT_W-1:0] miss_cnt_nxt [NUM_TYPES];

  logic             ev, is_br, miss, type_ok, sat_hit;
  logic [CNT_W-1:0] rd_mux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != ALL_ONES) ? v + ONE : v;
  endfunction

  function automatic logic at_max(input logic [CNT_W-1:0] v, input logic en);
    return en && v == ALL_ONES;
  endfunction

  always_comb begin
    ev      = !bubbleE && !freeze;
    is_br   = br_type != '0;
    miss    = ev && brFlush;
    // Out-of-range types still count toward the totals, never per type.
    type_ok = int'(br_type) < NUM_TYPES;
    sat_hit = 1'b0;

    tot_br_nxt   = sat_inc(tot_br, ev && is_br);
    tot_miss_nxt = sat_inc(tot_miss, miss);
    pred_t_nxt   = sat_inc(pred_t, ev && is_br && predict);
    instr_nxt    = sat_inc(instr, ev);
    sat_hit |= at_max(tot_br, ev && is_br);
    sat_hit |= at_max(tot_miss, miss);
    sat_hit |= at_max(pred_t, ev && is_br && predict);
    sat_hit |= at_max(instr, ev);

    // br_cnt[0] never increments (is_br is false for type 0).
    for (int t = 0; t < NUM_TYPES; t++) begin
      br_cnt_nxt[t]   = sat_inc(br_cnt[t], ev && is_br && type_ok && br_type == TYPE_W'(t));
      miss_cnt_nxt[t] = sat_inc(miss_cnt[t], miss && type_ok && br_type == TYPE_W'(t));
      sat_hit |= at_max(br_cnt[t], ev && is_br && type_ok && br_type == TYPE_W'(t));
      sat_hit |= at_max(miss_cnt[t], miss && type_ok && br_type == TYPE_W'(t));
    end

    // The new streak (already saturated) is what competes for the maximum.
    cur_streak_nxt = cur_streak;
    max_streak_nxt = max_streak;
    if (miss) begin
      cur_streak_nxt = sat_inc(cur_streak, 1'b1);
      sat_hit |= at_max(cur_streak, 1'b1);
      if (cur_streak_nxt > max_streak) max_streak_nxt = cur_streak_nxt;
    end else if (ev && is_br) begin
      cur_streak_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tot_br     <= '0;
      tot_miss   <= '0;
      pred_t     <= '0;
      max_streak <= '0;
      instr      <= '0;
      cur_streak <= '0;
      overflow   <= 1'b0;
      for (int t = 0; t < NUM_TYPES; t++) begin
        br_cnt[t]   <= '0;
        miss_cnt[t] <= '0;
      end
    end else if (clear) begin
      tot_br     <= '0;
      tot_miss   <= '0;
      pred_t     <= '0;
      max_streak <= '0;
      instr      <= '0;
      cur_streak <= '0;
      overflow   <= 1'b0;
      for (int t = 0; t < NUM_TYPES; t++) begin
        br_cnt[t]   <= '0;
        miss_cnt[t] <= '0;
      end
    end else begin
      // freeze needs no branch here: ev = 0 makes every *_nxt equal its state.
      tot_br     <= tot_br_nxt;
      tot_miss   <= tot_miss_nxt;
      pred_t     <= pred_t_nxt;
      max_streak <= max_streak_nxt;
      instr      <= instr_nxt;
      cur_streak <= cur_streak_nxt;
      overflow   <= overflow | sat_hit;
      for (int t = 0; t < NUM_TYPES; t++) begin
        br_cnt[t]   <= br_cnt_nxt[t];
        miss_cnt[t] <= miss_cnt_nxt[t];
      end
    end
  end

  // Read mux looks at current state, so a read returns pre-update/pre-clear values.
  always_comb begin
    rd_mux = '0;
    case (int'(rd.rd_addr))
      0: rd_mux = tot_br;
      1: rd_mux = tot_miss;
      2: rd_mux = pred_t;
      3: rd_mux = max_streak;
      4: rd_mux = instr;
      5: rd_mux = cur_streak;
      default: begin
        for (int t = 0; t < NUM_TYPES; t++) begin
          if (t != 0 && int'(rd.rd_addr) == 8 + t) rd_mux = br_cnt[t];
          if (int'(rd.rd_addr) == 16 + t)          rd_mux = miss_cnt[t];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) rd.rd_data <= rd_mux;
    end
  end

endmodule
